// File: rtl/mic_capture_ctrl.sv
// PDM microphone capture sequencer: generates M_CLK, discards a warm-up interval,
// packs 16 PDM bits MSB-first per word and writes them to a word-addressed buffer.
module mic_capture_ctrl #(
    parameter int unsigned CLK_DIV      = 42,
    parameter int unsigned WARMUP_TICKS = 4096,
    parameter int unsigned ADDR_W       = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              M_DATA,
    output logic              M_CLK,
    output logic              M_LRSEL,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned DIV_W  = $clog2(CLK_DIV);
    localparam int unsigned WARM_W = $clog2(WARMUP_TICKS + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_TICKS - 1);
    localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WC_ONE    = (ADDR_W + 1)'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WARMUP = 2'd1;
    localparam logic [1:0] RECORD = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]        state;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_next;
    logic [WARM_W-1:0] warm_cnt;
    logic [3:0]        bit_cnt;
    logic [15:0]       sreg;
    logic              stop_pend;
    logic              tick;
    logic              full;

    assign tick     = (div_cnt == DIV_LAST);
    assign div_next = tick ? '0 : div_cnt + DIV_ONE;
    assign full     = (mem_addr == '1);

    assign M_LRSEL = 1'b0;
    assign busy    = (state == WARMUP) || (state == RECORD);
    assign done    = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            warm_cnt   <= '0;
            bit_cnt    <= '0;
            sreg       <= '0;
            stop_pend  <= 1'b0;
            M_CLK      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    M_CLK   <= 1'b0;
                    div_cnt <= '0;
                    if (start) begin
                        state      <= WARMUP;
                        M_CLK      <= 1'b1;
                        warm_cnt   <= '0;
                        bit_cnt    <= '0;
                        sreg       <= '0;
                        stop_pend  <= 1'b0;
                        mem_addr   <= '0;
                        word_count <= '0;
                    end
                end
                WARMUP: begin
                    div_cnt <= div_next;
                    M_CLK   <= (div_next < DIV_HALF);
                    if (stop) begin
                        state <= DONE;
                        M_CLK <= 1'b0;
                    end else if (tick) begin
                        if (warm_cnt == WARM_LAST)
                            state <= RECORD;
                        else
                            warm_cnt <= warm_cnt + WARM_ONE;
                    end
                end
                RECORD: begin
                    div_cnt <= div_next;
                    M_CLK   <= (div_next < DIV_HALF);
                    if (stop)
                        stop_pend <= 1'b1;
                    if (tick) begin
                        sreg    <= {sreg[14:0], M_DATA};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= {sreg[14:0], M_DATA};
                        end
                    end
                    // Bookkeeping happens in the write cycle itself; a stop seen
                    // here (or earlier) ends the capture after this word.
                    if (mem_we) begin
                        word_count <= word_count + WC_ONE;
                        if (!full)
                            mem_addr <= mem_addr + ADDR_ONE;
                        if (stop_pend || stop || full) begin
                            state <= DONE;
                            M_CLK <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    M_CLK   <= 1'b0;
                    div_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Scoreboard bench for mic_capture_ctrl: expected writes and done pulses are queued
// when a capture is launched and compared as the DUT produces them.
module tb_mic_capture_ctrl;

    localparam int D  = 4;
    localparam int W  = 2;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          M_DATA = 1'b0;
    logic          M_CLK, M_LRSEL, mem_we, busy, done;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [AW:0]   word_count;

    mic_capture_ctrl #(.CLK_DIV(D), .WARMUP_TICKS(W), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .M_DATA(M_DATA),
        .M_CLK(M_CLK), .M_LRSEL(M_LRSEL), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct { int cyc; int addr; int data; } wr_t;
    typedef struct { int cyc; int wc; } dn_t;
    wr_t exp_wr[$];
    dn_t exp_dn[$];

    logic pbits [0:199];
    int   t0 = 0;
    bit   gen_on = 1'b0;
    logic prev_we = 1'b0;

    task automatic check_val(input string tag, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, want, want, cyc);
        end
    endtask

    // Each PDM period holds one bit constant; period p spans cycles t0+1+4p .. t0+4+4p.
    always @(posedge clk) begin : gen
        int p;
        #2;
        if (gen_on && cyc > t0) begin
            p = (cyc - t0 - 1) / D;
            M_DATA = (p < 200) ? pbits[p] : 1'b0;
        end else begin
            M_DATA = 1'b0;
        end
    end

    always @(negedge clk) begin : mon
        wr_t e;
        dn_t d;
        if (!reset) begin
            if (mem_we) begin
                check_val("we_gap", int'(prev_we), 0);
                if (exp_wr.size() == 0) begin
                    check_val("we_unexpected", cyc, -1);
                end else begin
                    e = exp_wr.pop_front();
                    check_val("we_cycle", cyc, e.cyc);
                    check_val("we_addr", int'(mem_addr), e.addr);
                    check_val("we_data", int'(mem_wdata), e.data);
                end
            end
            if (done) begin
                check_val("done_busy", int'(busy), 0);
                check_val("done_mclk", int'(M_CLK), 0);
                if (exp_dn.size() == 0) begin
                    check_val("done_unexpected", cyc, -1);
                end else begin
                    d = exp_dn.pop_front();
                    check_val("done_cycle", cyc, d.cyc);
                    check_val("done_wc", int'(word_count), d.wc);
                end
            end
        end
        prev_we <= mem_we;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    function automatic int word_of(input int k);
        int w = 0;
        for (int i = 0; i < 16; i++)
            w = (w << 1) | int'(pbits[W + 16 * k + i]);
        return w;
    endfunction

    // mode 0: alternating 1,0 from period 0 (recorded bit 0 is 1); 1: all ones; 2: random
    task automatic begin_capture(input int mode, input bit with_stop, output int t);
        for (int p = 0; p < 200; p++)
            pbits[p] = (mode == 0) ? logic'(p % 2 == 0) :
                       (mode == 1) ? 1'b1 : logic'($urandom_range(0, 1));
        start  = 1'b1;
        stop   = with_stop;
        t      = cyc;
        t0     = cyc;
        gen_on = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic push_words(input int t, input int n);
        wr_t e;
        for (int k = 0; k < n; k++) begin
            e.cyc  = t + (W + 16 * (k + 1)) * D + 1;
            e.addr = k;
            e.data = word_of(k);
            exp_wr.push_back(e);
        end
    endtask

    task automatic push_done(input int c, input int wc);
        dn_t d;
        d.cyc = c;
        d.wc  = wc;
        exp_dn.push_back(d);
    endtask

    task automatic pulse_stop(input int c);
        goto(c);
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic finish_scn(input int c);
        goto(c);
        check_val("wr_left", exp_wr.size(), 0);
        check_val("done_left", exp_dn.size(), 0);
        exp_wr.delete();
        exp_dn.delete();
        gen_on = 1'b0;
    endtask

    initial begin
        int t;
        repeat (3) step();
        reset = 1'b0;
        repeat (20) step();
        check_val("idle_mclk", int'(M_CLK), 0);
        check_val("idle_busy", int'(busy), 0);
        check_val("idle_we", int'(mem_we), 0);
        check_val("idle_lrsel", int'(M_LRSEL), 0);
        check_val("idle_wc", int'(word_count), 0);

        // Alternating data, M_CLK shape, stop 10 cycles after first write
        begin_capture(0, 1'b0, t);
        check_val("start_busy", int'(busy), 1);
        for (int i = 1; i <= 8; i++) begin
            goto(t + i);
            check_val("mclk_wave", int'(M_CLK), (((i - 1) % D) < D / 2) ? 1 : 0);
        end
        push_words(t, 2);
        push_done(t + 138, 2);
        pulse_stop(t + 83);
        finish_scn(t + 150);

        // Constant ones until full; stray start mid-capture
        step();
        begin_capture(1, 1'b0, t);
        push_words(t, 8);
        push_done(t + 522, 8);
        goto(t + 200);
        start = 1'b1;
        step();
        start = 1'b0;
        goto(t + 523);
        check_val("full_addr", int'(mem_addr), 7);
        check_val("full_wc", int'(word_count), 8);
        check_val("full_busy", int'(busy), 0);
        finish_scn(t + 540);

        // Stop during warm-up
        step();
        begin_capture(2, 1'b0, t);
        push_done(t + 4, 0);
        pulse_stop(t + 3);
        finish_scn(t + 40);

        // Start and stop together in IDLE, random data, later stop
        step();
        begin_capture(2, 1'b1, t);
        push_words(t, 3);
        push_done(t + 202, 3);
        pulse_stop(t + 150);
        finish_scn(t + 230);

        // Stop coincident with the write strobe
        step();
        begin_capture(2, 1'b0, t);
        push_words(t, 1);
        push_done(t + 74, 1);
        pulse_stop(t + 73);
        finish_scn(t + 100);

        // Asynchronous reset mid-RECORD, between ticks
        step();
        begin_capture(2, 1'b0, t);
        push_words(t, 1);
        goto(t + 90);
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_mclk", int'(M_CLK), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_we", int'(mem_we), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_addr", int'(mem_addr), 0);
        check_val("rst_wdata", int'(mem_wdata), 0);
        check_val("rst_wc", int'(word_count), 0);
        check_val("rst_lrsel", int'(M_LRSEL), 0);
        step();
        step();
        reset = 1'b0;
        gen_on = 1'b0;
        finish_scn(t + 160);
        check_val("post_rst_busy", int'(busy), 0);
        check_val("post_rst_wc", int'(word_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
